// File: rtl/key_conditioner.sv
// Synchronizes and debounces active-low pushbuttons, one independent slice per key,
// producing a clean level, one-cycle press/release pulses and a press-toggled bit.
module key_conditioner #(
  parameter int NUM_KEYS  = 3,
  parameter int DB_CYCLES = 250000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_toggle
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    UP,
    DB_DN,
    DOWN,
    DB_UP
  } state_t;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic          s1;
    logic          s2;
    state_t        state;
    logic [CW-1:0] cnt;
    logic          level_q;
    logic          press_q;
    logic          release_q;
    logic          toggle_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        s1        <= 1'b1;
        s2        <= 1'b1;
        state     <= UP;
        cnt       <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        toggle_q  <= 1'b0;
      end else begin
        // NOTE: non-blocking, so s2 takes the old s1 and the pair forms two real flops.
        s1        <= key_n[i];
        s2        <= s1;
        press_q   <= 1'b0;
        release_q <= 1'b0;

        case (state)
          UP: begin
            if (!s2) begin
              state <= DB_DN;
              cnt   <= CW'(1);
            end
          end
          DB_DN: begin
            if (s2) begin
              state <= UP;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state    <= DOWN;
              cnt      <= '0;
              level_q  <= 1'b1;
              press_q  <= 1'b1;
              toggle_q <= ~toggle_q;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DOWN: begin
            if (s2) begin
              state <= DB_UP;
              cnt   <= CW'(1);
            end
          end
          DB_UP: begin
            if (!s2) begin
              state <= DOWN;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state     <= UP;
              cnt       <= '0;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= UP;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
    assign key_toggle[i]  = toggle_q;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DB_CYCLES=4, NUM_KEYS=3; inputs change
// 1 time unit after each rising edge, outputs are sampled at that same point.
module tb_key_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] key_n = 3'b111;
  logic [2:0] key_level;
  logic [2:0] key_press;
  logic [2:0] key_release;
  logic [2:0] key_toggle;

  int n_cmp = 0;
  int n_err = 0;

  key_conditioner #(.NUM_KEYS(3), .DB_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_n      (key_n),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_toggle (key_toggle)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive key 1 for n cycles while key 0 and key 2 are idle; nothing may be accepted.
  task automatic drive_k1_quiet(input logic v, input int n, input string tag);
    key_n[1] = v;
    repeat (n) begin
      tick(1);
      check({tag, " press"}, key_press, 3'b000);
      check({tag, " level"}, key_level, 3'b000);
    end
  endtask

  task automatic cycle_k2(input logic [2:0] tog_exp);
    key_n[2] = 1'b0;
    tick(6);
    check("k2 toggle after press", key_toggle, tog_exp);
    key_n[2] = 1'b1;
    tick(6);
    check("k2 toggle after release", key_toggle, tog_exp);
    tick(1);
  endtask

  initial begin
    // Reset values
    tick(3);
    check("reset level", key_level, 3'b000);
    check("reset press", key_press, 3'b000);
    check("reset release", key_release, 3'b000);
    check("reset toggle", key_toggle, 3'b000);
    rst = 1'b0;
    tick(10);
    check("idle level", key_level, 3'b000);
    check("idle press", key_press, 3'b000);
    check("idle toggle", key_toggle, 3'b000);

    // Clean press and release on key 0
    key_n = 3'b110;
    tick(5);
    check("k0 level before accept", key_level, 3'b000);
    check("k0 press before accept", key_press, 3'b000);
    tick(1);
    check("k0 level at accept", key_level, 3'b001);
    check("k0 press pulse", key_press, 3'b001);
    check("k0 toggle", key_toggle, 3'b001);
    tick(1);
    check("k0 press one cycle", key_press, 3'b000);
    check("k0 level held", key_level, 3'b001);
    tick(13);
    key_n = 3'b111;
    tick(5);
    check("k0 level before release", key_level, 3'b001);
    check("k0 release early", key_release, 3'b000);
    tick(1);
    check("k0 level released", key_level, 3'b000);
    check("k0 release pulse", key_release, 3'b001);
    check("k0 no press on release", key_press, 3'b000);
    tick(1);
    check("k0 release one cycle", key_release, 3'b000);
    check("k0 toggle kept", key_toggle, 3'b001);

    // Bounce filtering on key 1
    drive_k1_quiet(1'b0, 3, "bounce low3");
    drive_k1_quiet(1'b1, 1, "bounce high1");
    drive_k1_quiet(1'b0, 2, "bounce low2");
    drive_k1_quiet(1'b1, 1, "bounce high1b");
    key_n[1] = 1'b0;
    repeat (5) begin
      tick(1);
      check("k1 final low pre-accept", key_press, 3'b000);
    end
    tick(1);
    check("k1 press after bounce", key_press, 3'b010);
    check("k1 level after bounce", key_level, 3'b010);
    check("k1 toggle", key_toggle, 3'b011);
    tick(4);
    key_n[1] = 1'b1;
    tick(6);
    check("k1 release pulse", key_release, 3'b010);
    tick(1);
    drive_k1_quiet(1'b0, 3, "glitch low");
    drive_k1_quiet(1'b1, 8, "glitch recover");
    check("k1 toggle after glitch", key_toggle, 3'b011);

    // Toggle on key 2
    cycle_k2(3'b111);
    cycle_k2(3'b011);
    cycle_k2(3'b111);

    // Simultaneous keys 0 and 2
    key_n = 3'b010;
    tick(5);
    check("simul press early", key_press, 3'b000);
    tick(1);
    check("simul press", key_press, 3'b101);
    check("simul level", key_level, 3'b101);
    check("simul toggle", key_toggle, 3'b010);
    tick(1);
    check("simul press one cycle", key_press, 3'b000);
    key_n = 3'b111;
    tick(6);
    check("simul release", key_release, 3'b101);
    tick(1);

    // Reset mid-debounce, key 0 held through it
    key_n = 3'b110;
    tick(3);
    check("pre-reset press", key_press, 3'b000);
    rst = 1'b1;
    tick(1);
    check("mid-reset level", key_level, 3'b000);
    check("mid-reset press", key_press, 3'b000);
    check("mid-reset toggle", key_toggle, 3'b000);
    rst = 1'b0;
    tick(5);
    check("post-reset press early", key_press, 3'b000);
    tick(1);
    check("post-reset press", key_press, 3'b001);
    check("post-reset toggle", key_toggle, 3'b001);
    check("post-reset level", key_level, 3'b001);

    // Reset while DOWN
    tick(2);
    check("down level", key_level, 3'b001);
    rst = 1'b1;
    tick(1);
    check("reset in down level", key_level, 3'b000);
    check("reset in down toggle", key_toggle, 3'b000);
    tick(2);
    check("reset held press", key_press, 3'b000);
    check("reset held release", key_release, 3'b000);
    rst = 1'b0;
    tick(5);
    check("re-debounce press early", key_press, 3'b000);
    tick(1);
    check("re-debounce press", key_press, 3'b001);
    check("re-debounce toggle", key_toggle, 3'b001);
    key_n = 3'b111;
    tick(8);
    check("final level", key_level, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
